// File: rtl/eth_speed_adapt.sv
// eth_speed_adapt: qualifies the PHY speed code, publishes link/speed,
// and drives the RGMII tx clock-enable cadence. Optional stats: SPEED_STAT_EN.
module eth_speed_adapt #(
  parameter int STABLE_CNT = 1024,
  parameter int GUARD_CNT  = 16,
  parameter int QCNT_W     = 11,
  parameter int GCNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed_mode,
  output logic       link_up,
  output logic [1:0] speed_sel,
  output logic       speed_chg,
  output logic       tx_ce,
  output logic       ddr_en
`ifdef SPEED_STAT_EN
  ,
  output logic [15:0] chg_cnt,
  output logic [7:0]  down_cnt
`endif
);

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(STABLE_CNT - 1);
  localparam logic [GCNT_W-1:0] GMAX = GCNT_W'(GUARD_CNT - 1);

  logic [1:0]        spd_r;
  logic [1:0]        cand;
  logic [QCNT_W-1:0] qcnt;
  state_t            state;
  logic [GCNT_W-1:0] gcnt;
  logic [6:0]        div;
  logic [6:0]        div_max;
  logic [6:0]        div_nxt;
  logic              accepted;

  // Register the raw PHY code once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spd_r <= 2'b00;
    else     spd_r <= speed_mode;
  end

  // Track a candidate code and count how long it has held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 2'b00;
      qcnt <= '0;
    end else if (spd_r != cand) begin
      cand <= spd_r;
      qcnt <= '0;
    end else if (qcnt != QMAX) begin
      qcnt <= qcnt + QCNT_W'(1);
    end
  end

  assign accepted = (qcnt == QMAX) && (cand != speed_sel);

  // Divider terminal count for the qualified speed.
  always_comb begin
    div_max = 7'd0;
    case (speed_sel)
      2'b10:   div_max = 7'd9;
      2'b01:   div_max = 7'd99;
      default: div_max = 7'd0;
    endcase
  end

  assign div_nxt = (div == div_max) ? 7'd0 : div + 7'd1;
  assign ddr_en  = (speed_sel == 2'b11);

  // Link FSM: an acceptance always overrides the guard/divider progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DOWN;
      speed_sel <= 2'b00;
      speed_chg <= 1'b0;
      link_up   <= 1'b0;
      tx_ce     <= 1'b0;
      gcnt      <= '0;
      div       <= '0;
    end else begin
      speed_chg <= 1'b0;
      if (accepted) begin
        speed_chg <= 1'b1;
        speed_sel <= cand;
        link_up   <= 1'b0;
        tx_ce     <= 1'b0;
        gcnt      <= '0;
        div       <= '0;
        state     <= (cand == 2'b00) ? DOWN : GUARD;
      end else begin
        case (state)
          GUARD: begin
            if (gcnt == GMAX) begin
              state   <= RUN;
              link_up <= 1'b1;
              tx_ce   <= 1'b1;
              div     <= '0;
            end else begin
              gcnt <= gcnt + GCNT_W'(1);
            end
          end
          RUN: begin
            div   <= div_nxt;
            tx_ce <= (div_nxt == 7'd0);
          end
          default: begin
            link_up <= 1'b0;
            tx_ce   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPEED_STAT_EN
  // Saturating counts of speed changes and of link drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt  <= '0;
      down_cnt <= '0;
    end else if (accepted) begin
      if (chg_cnt != 16'hFFFF) chg_cnt <= chg_cnt + 16'd1;
      if (cand == 2'b00 && state != DOWN && down_cnt != 8'hFF)
        down_cnt <= down_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_speed_adapt.sv
// tb_eth_speed_adapt: directed plus random stimulus checked every cycle
// against a sample-history reference model of eth_speed_adapt.
module tb_eth_speed_adapt;

  localparam int S = 8;
  localparam int G = 4;
  localparam int M_DOWN  = 0;
  localparam int M_GUARD = 1;
  localparam int M_RUN   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed_mode;
  logic       link_up;
  logic [1:0] speed_sel;
  logic       speed_chg;
  logic       tx_ce;
  logic       ddr_en;
`ifdef SPEED_STAT_EN
  logic [15:0] chg_cnt;
  logic [7:0]  down_cnt;
`endif

  always #4 clk = ~clk;

  eth_speed_adapt #(
    .STABLE_CNT(S),
    .GUARD_CNT (G),
    .QCNT_W    (11),
    .GCNT_W    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .speed_mode(speed_mode),
    .link_up   (link_up),
    .speed_sel (speed_sel),
    .speed_chg (speed_chg),
    .tx_ce     (tx_ce),
    .ddr_en    (ddr_en)
`ifdef SPEED_STAT_EN
    ,
    .chg_cnt   (chg_cnt),
    .down_cnt  (down_cnt)
`endif
  );

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [1:0] h[$];
  int m_sel;
  int m_st;
  int m_gleft;
  int m_age;
  bit m_chg;
  int m_nchg;
  int m_ndown;

  function automatic int period(input int s);
    case (s)
      3:       return 1;
      2:       return 10;
      1:       return 100;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    h.delete();
    for (int i = 0; i <= S; i++) h.push_back(2'b00);
    m_sel   = 0;
    m_st    = M_DOWN;
    m_gleft = 0;
    m_age   = 0;
    m_chg   = 0;
    m_nchg  = 0;
    m_ndown = 0;
  endtask

  // A code is accepted when the S samples ending two edges ago all agree
  // and differ from the published speed.
  task automatic model_edge(input logic [1:0] smp);
    bit acc;
    int v;
    v   = int'(h[S-1]);
    acc = 1;
    for (int i = 0; i < S; i++) if (int'(h[i]) != v) acc = 0;
    if (v == m_sel) acc = 0;
    m_chg = acc;
    if (acc) begin
      m_sel = v;
      if (m_nchg < 16'hFFFF) m_nchg++;
      if (v == 0) begin
        if (m_ndown < 255) m_ndown++;
        m_st = M_DOWN;
      end else begin
        m_st    = M_GUARD;
        m_gleft = G;
      end
    end else if (m_st == M_GUARD) begin
      m_gleft--;
      if (m_gleft == 0) begin
        m_st  = M_RUN;
        m_age = 0;
      end
    end else if (m_st == M_RUN) begin
      m_age++;
    end
    h.push_back(smp);
    void'(h.pop_front());
  endtask

  task automatic check_outs();
    chk("link_up", 32'(link_up), 32'(m_st == M_RUN));
    chk("speed_sel", 32'(speed_sel), 32'(m_sel));
    chk("speed_chg", 32'(speed_chg), 32'(m_chg));
    chk("tx_ce", 32'(tx_ce),
        32'(m_st == M_RUN && (m_age % period(m_sel)) == 0));
    chk("ddr_en", 32'(ddr_en), 32'(m_sel == 3));
`ifdef SPEED_STAT_EN
    chk("chg_cnt", 32'(chg_cnt), 32'(m_nchg));
    chk("down_cnt", 32'(down_cnt), 32'(m_ndown));
`endif
  endtask

  task automatic step(input logic [1:0] m);
    speed_mode = m;
    @(posedge clk);
    model_edge(m);
    #1;
    check_outs();
    cyc++;
  endtask

  task automatic hold(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) step(m);
  endtask

  task automatic to_run(input logic [1:0] m);
    for (int i = 0; i < S + G + 20; i++) begin
      if (m_st == M_RUN && m_sel == int'(m)) break;
      step(m);
    end
    chk("reach_run", 32'(m_st == M_RUN && m_sel == int'(m)), 32'd1);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_link"}, 32'(link_up), 32'd0);
    chk({tag, "_sel"}, 32'(speed_sel), 32'd0);
    chk({tag, "_chg"}, 32'(speed_chg), 32'd0);
    chk({tag, "_ce"}, 32'(tx_ce), 32'd0);
    chk({tag, "_ddr"}, 32'(ddr_en), 32'd0);
  endtask

  task automatic reset_mid(input string tag);
    #2;
    rst = 1'b1;
    #1;
    zero_outs(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    int pt[$];
    logic [1:0] v;
    int len;

    rst        = 1'b1;
    speed_mode = 2'b00;
    model_reset();
    #10;
    zero_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    hold(2'b00, 3);
    lat = -1;
    for (int i = 1; i <= 24; i++) begin
      step(2'b11);
      if (speed_chg && lat < 0) lat = i - 1;
    end
    chk("lat_1000", 32'(lat), 32'(S + 1));
    chk("run_1000", 32'(link_up), 32'd1);

    hold(2'b00, S + 4);
    chk("down_ok", 32'(link_up), 32'd0);
    to_run(2'b10);
    cnt = int'(tx_ce);
    for (int i = 0; i < 99; i++) begin
      step(2'b10);
      cnt += int'(tx_ce);
    end
    chk("pulses_100m", 32'(cnt), 32'd10);
    chk("ddr_100m", 32'(ddr_en), 32'd0);

    to_run(2'b01);
    pt.delete();
    if (tx_ce) pt.push_back(cyc);
    for (int i = 0; i < 301; i++) begin
      step(2'b01);
      if (tx_ce) pt.push_back(cyc);
    end
    chk("npulse_10m", 32'(pt.size()), 32'd4);
    for (int i = 1; i < pt.size() && i < 4; i++)
      chk("space_10m", 32'(pt[i] - pt[i-1]), 32'd100);

    to_run(2'b11);
    hold(2'b11, 10);
    cnt = 0;
    lat = 0;
    for (int i = 0; i < 25; i++) begin
      step((i < 5) ? 2'b00 : 2'b11);
      cnt += int'(speed_chg);
      lat += int'(!link_up);
    end
    chk("glitch_chg", 32'(cnt), 32'd0);
    chk("glitch_link", 32'(lat), 32'd0);

    to_run(2'b10);
    hold(2'b10, 7);
    lat = -1;
    for (int i = 1; i <= S + 5; i++) begin
      step(2'b00);
      if (speed_chg && lat < 0) lat = i - 1;
    end
    chk("lat_down", 32'(lat), 32'(S + 1));
    chk("down_link", 32'(link_up), 32'd0);
    to_run(2'b11);

    for (int i = 0; i < S + G + 20 && m_st != M_GUARD; i++) step(2'b10);
    chk("in_guard", 32'(m_st), 32'(M_GUARD));
    reset_mid("rst_guard");
    hold(2'b00, 20);
    to_run(2'b11);
    hold(2'b11, 5);
    reset_mid("rst_run");
    hold(2'b00, 10);

`ifdef SPEED_STAT_EN
    to_run(2'b10);
    @(negedge clk);
    force dut.chg_cnt = 16'hFFFE;
    #1;
    release dut.chg_cnt;
    m_nchg = 16'hFFFE;
    to_run(2'b11);
    to_run(2'b01);
    chk("chg_sat", 32'(chg_cnt), 32'hFFFF);
    reset_mid("rst_stat");
    chk("chg_clr", 32'(chg_cnt), 32'd0);
`endif

    for (int s = 0; s < 40; s++) begin
      v = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) len = int'($urandom_range(1, S + 2));
      else                           len = int'($urandom_range(S + 1, 150));
      hold(v, len);
      if ($urandom_range(0, 15) == 0) reset_mid("rst_rand");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
